// File: rtl/morse_keyer_if.sv
// Character handshake between a character source and the Morse keyer.
interface morse_keyer_if;
  localparam int unsigned CHAR_W = 6;

  logic [CHAR_W-1:0] char_in;
  logic              char_valid;
  logic              char_ready;

  modport master (output char_in, output char_valid, input char_ready);
  modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/morse_keyer.sv
// Morse transmitter: accepts a character index, keys its dot/dash pattern on key_out
// with 1-unit element gaps, 3-unit letter gaps and 4 extra units for a word space.
module morse_keyer #(
  parameter int unsigned UNIT_TICKS = 4
) (
  input  logic          mid_clk,
  input  logic          rst,
  morse_keyer_if.slave  bus,
  output logic          key_out,
  output logic          elem_dot,
  output logic          elem_dash,
  output logic          char_done,
  output logic          err
);
  localparam int unsigned CHAR_W = 6;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned PAT_W  = 5;
  localparam int unsigned TICK_W = $clog2(4 * UNIT_TICKS);

  localparam logic [TICK_W-1:0] T_UNIT  = TICK_W'(UNIT_TICKS - 1);
  localparam logic [TICK_W-1:0] T_THREE = TICK_W'(3 * UNIT_TICKS - 1);
  localparam logic [TICK_W-1:0] T_FOUR  = TICK_W'(4 * UNIT_TICKS - 1);
  localparam logic [CHAR_W-1:0] LAST_SYM   = CHAR_W'(35);
  localparam logic [CHAR_W-1:0] WORD_SPACE = CHAR_W'(36);

  typedef enum logic [2:0] {IDLE, MARK, GAP, LETTER_GAP, WORD_GAP} state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick, tick_nxt;
  logic [PAT_W-1:0]    pat, pat_nxt;
  logic [LEN_W-1:0]    elems, elems_nxt;
  logic                dash, dash_nxt;
  logic                done_nxt, err_nxt;
  logic                ready;
  logic                accept;
  logic                mark_entry;
  logic [LEN_W-1:0]    rom_len;
  logic [PAT_W-1:0]    rom_pat;

  assign bus.char_ready = ready;
  assign accept         = bus.char_valid && ready;
  assign mark_entry     = (state_nxt == MARK) && (state != MARK);

  // Pattern ROM: length and left-aligned element bits, first element in the MSB, 1 = dash.
  always_comb begin
    {rom_len, rom_pat} = '0;
    case (bus.char_in)
      6'd0:  {rom_len, rom_pat} = {3'd2, 5'b01000}; // A
      6'd1:  {rom_len, rom_pat} = {3'd4, 5'b10000}; // B
      6'd2:  {rom_len, rom_pat} = {3'd4, 5'b10100}; // C
      6'd3:  {rom_len, rom_pat} = {3'd3, 5'b10000}; // D
      6'd4:  {rom_len, rom_pat} = {3'd1, 5'b00000}; // E
      6'd5:  {rom_len, rom_pat} = {3'd4, 5'b00100}; // F
      6'd6:  {rom_len, rom_pat} = {3'd3, 5'b11000}; // G
      6'd7:  {rom_len, rom_pat} = {3'd4, 5'b00000}; // H
      6'd8:  {rom_len, rom_pat} = {3'd2, 5'b00000}; // I
      6'd9:  {rom_len, rom_pat} = {3'd4, 5'b01110}; // J
      6'd10: {rom_len, rom_pat} = {3'd3, 5'b10100}; // K
      6'd11: {rom_len, rom_pat} = {3'd4, 5'b01000}; // L
      6'd12: {rom_len, rom_pat} = {3'd2, 5'b11000}; // M
      6'd13: {rom_len, rom_pat} = {3'd2, 5'b10000}; // N
      6'd14: {rom_len, rom_pat} = {3'd3, 5'b11100}; // O
      6'd15: {rom_len, rom_pat} = {3'd4, 5'b01100}; // P
      6'd16: {rom_len, rom_pat} = {3'd4, 5'b11010}; // Q
      6'd17: {rom_len, rom_pat} = {3'd3, 5'b01000}; // R
      6'd18: {rom_len, rom_pat} = {3'd3, 5'b00000}; // S
      6'd19: {rom_len, rom_pat} = {3'd1, 5'b10000}; // T
      6'd20: {rom_len, rom_pat} = {3'd3, 5'b00100}; // U
      6'd21: {rom_len, rom_pat} = {3'd4, 5'b00010}; // V
      6'd22: {rom_len, rom_pat} = {3'd3, 5'b01100}; // W
      6'd23: {rom_len, rom_pat} = {3'd4, 5'b10010}; // X
      6'd24: {rom_len, rom_pat} = {3'd4, 5'b10110}; // Y
      6'd25: {rom_len, rom_pat} = {3'd4, 5'b11000}; // Z
      6'd26: {rom_len, rom_pat} = {3'd5, 5'b01111}; // 1
      6'd27: {rom_len, rom_pat} = {3'd5, 5'b00111}; // 2
      6'd28: {rom_len, rom_pat} = {3'd5, 5'b00011}; // 3
      6'd29: {rom_len, rom_pat} = {3'd5, 5'b00001}; // 4
      6'd30: {rom_len, rom_pat} = {3'd5, 5'b00000}; // 5
      6'd31: {rom_len, rom_pat} = {3'd5, 5'b10000}; // 6
      6'd32: {rom_len, rom_pat} = {3'd5, 5'b11000}; // 7
      6'd33: {rom_len, rom_pat} = {3'd5, 5'b11100}; // 8
      6'd34: {rom_len, rom_pat} = {3'd5, 5'b11110}; // 9
      6'd35: {rom_len, rom_pat} = {3'd5, 5'b11111}; // 0
      default: {rom_len, rom_pat} = '0;
    endcase
  end

  // Next-state logic; the tick counter restarts from zero on every state change.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick + TICK_W'(1);
    pat_nxt   = pat;
    elems_nxt = elems;
    dash_nxt  = dash;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        tick_nxt = '0;
        if (accept) begin
          if (bus.char_in <= LAST_SYM) begin
            state_nxt = MARK;
            dash_nxt  = rom_pat[PAT_W-1];
            pat_nxt   = rom_pat << 1;
            elems_nxt = rom_len;
          end else if (bus.char_in == WORD_SPACE) begin
            state_nxt = WORD_GAP;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      MARK: begin
        if (tick == (dash ? T_THREE : T_UNIT)) begin
          tick_nxt = '0;
          if (elems > LEN_W'(1)) begin
            state_nxt = GAP;
            elems_nxt = elems - LEN_W'(1);
          end else begin
            state_nxt = LETTER_GAP;
          end
        end
      end
      GAP: begin
        if (tick == T_UNIT) begin
          tick_nxt  = '0;
          state_nxt = MARK;
          dash_nxt  = pat[PAT_W-1];
          pat_nxt   = pat << 1;
        end
      end
      LETTER_GAP: begin
        if (tick == T_THREE) begin
          tick_nxt  = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      WORD_GAP: begin
        if (tick == T_FOUR) begin
          tick_nxt  = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so they line up with it.
  always_ff @(posedge mid_clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      pat       <= '0;
      elems     <= '0;
      dash      <= 1'b0;
      key_out   <= 1'b0;
      elem_dot  <= 1'b0;
      elem_dash <= 1'b0;
      char_done <= 1'b0;
      err       <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick      <= tick_nxt;
      pat       <= pat_nxt;
      elems     <= elems_nxt;
      dash      <= dash_nxt;
      key_out   <= (state_nxt == MARK);
      elem_dot  <= mark_entry && !dash_nxt;
      elem_dash <= mark_entry && dash_nxt;
      char_done <= done_nxt;
      err       <= err_nxt;
      ready     <= (state_nxt == IDLE);
    end
  end
endmodule

// File: tb/tb_morse_keyer.sv
// Random and directed stimulus for morse_keyer; a monitor decodes key_out back into
// dot/dash strings and checks them and their timing against a Morse table.
module tb_morse_keyer;
  localparam int U = 4;
  localparam int K_CHAR = 0;
  localparam int K_SPACE = 1;
  localparam int K_INV = 2;

  typedef struct {
    int kind;
    int idx;
    int acc;
  } exp_t;

  logic mid_clk;
  logic rst;
  logic key_out, elem_dot, elem_dash, char_done, err;

  morse_keyer_if bus ();

  morse_keyer #(.UNIT_TICKS(U)) dut (
    .mid_clk   (mid_clk),
    .rst       (rst),
    .bus       (bus),
    .key_out   (key_out),
    .elem_dot  (elem_dot),
    .elem_dash (elem_dash),
    .char_done (char_done),
    .err       (err)
  );

  string tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.", "-----"};

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   drv_fail = 0;
  bit   stim_done = 0;

  initial mid_clk = 1'b0;
  always #5 mid_clk = ~mid_clk;

  function automatic string exp_str(input exp_t e);
    return (e.kind == K_CHAR) ? tab[e.idx] : "";
  endfunction

  // Occupancy in units: marks, inter-element gaps, letter gap; a word space is 4 units.
  function automatic int exp_units(input exp_t e);
    string s;
    int n;
    if (e.kind == K_SPACE) return 4;
    s = tab[e.idx];
    n = 0;
    for (int i = 0; i < s.len(); i++) n += (s.getc(i) == 8'h2d) ? 3 : 1;
    return n + (s.len() - 1) + 3;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, wanted %0d", name, cyc, act, req);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got \"%s\", wanted \"%s\"", name, cyc, act, req);
    end
  endtask

  // Driver: accept happens at the posedge following a negedge that sees valid && ready.
  task automatic send(input int idx);
    int w;
    exp_t e;
    if (drv_fail) return;
    bus.char_in    = 6'(idx);
    bus.char_valid = 1'b1;
    w = 0;
    while (!bus.char_ready && w < 3000) begin
      @(negedge mid_clk);
      w++;
    end
    if (w >= 3000) begin
      drv_fail = 1'b1;
      return;
    end
    e.kind = (idx <= 35) ? K_CHAR : (idx == 36) ? K_SPACE : K_INV;
    e.idx  = idx;
    e.acc  = cyc + 1;
    q.push_back(e);
    @(negedge mid_clk);
  endtask

  initial begin
    int dots;
    int w;
    rst = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_in = '0;
    repeat (3) @(negedge mid_clk);
    rst = 1'b0;
    repeat (2) @(negedge mid_clk);

    send(4);  bus.char_valid = 1'b0; repeat (2) @(negedge mid_clk);
    send(0);  bus.char_valid = 1'b0; repeat (2) @(negedge mid_clk);
    send(35); send(4); bus.char_valid = 1'b0;
    send(36); bus.char_valid = 1'b0;
    send(50); bus.char_valid = 1'b0; repeat (5) @(negedge mid_clk);

    // S aborted by reset during its second dot, then T
    send(18); bus.char_valid = 1'b0;
    dots = 0;
    w = 0;
    while (w < 500) begin
      if (elem_dot) dots++;
      if (dots == 2) break;
      @(negedge mid_clk);
      w++;
    end
    if (dots != 2) drv_fail = 1'b1;
    rst = 1'b1;
    @(negedge mid_clk);
    rst = 1'b0;
    @(negedge mid_clk);
    send(19); bus.char_valid = 1'b0;

    for (int i = 0; i < 36; i++) send(i);
    bus.char_valid = 1'b0;

    repeat (40) begin
      send(int'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) begin
        bus.char_valid = 1'b0;
        repeat ($urandom_range(0, 6)) @(negedge mid_clk);
      end
    end
    bus.char_valid = 1'b0;
    stim_done = 1'b1;
  end

  // Monitor state
  bit    prev_key = 1'b0;
  bit    in_rst = 1'b0;
  bit    mark_dash = 1'b0;
  int    run = 0;
  int    space_run = 0;
  int    settle = 0;
  string cur = "";

  always @(posedge mid_clk) begin
    bit    start;
    string sym;
    exp_t  f;
    cyc++;
    #1;
    if (rst) begin
      chk("rst_key_out", int'(key_out), 0);
      chk("rst_char_ready", int'(bus.char_ready), 0);
      chk("rst_char_done", int'(char_done), 0);
      chk("rst_strobes", int'(elem_dot) + int'(elem_dash) + int'(err), 0);
      q.delete();
      cur = "";
      run = 0;
      space_run = 0;
      prev_key = 1'b0;
      in_rst = 1'b1;
    end else begin
      if (in_rst) chk("ready_after_rst", int'(bus.char_ready), 1);
      in_rst = 1'b0;

      start = key_out && !prev_key;
      if (start) begin
        chk("mark_strobe_count", int'(elem_dot) + int'(elem_dash), 1);
        if (cur.len() == 0 && q.size() > 0) chk("first_mark_cycle", cyc - q[0].acc, 0);
        else if (cur.len() > 0) chk("element_gap", space_run, U);
        mark_dash = elem_dash;
        run = 0;
      end else if (elem_dot || elem_dash) begin
        chk("stray_strobe", int'(elem_dot) + int'(elem_dash), 0);
      end

      if (key_out) begin
        run++;
      end else if (prev_key) begin
        if (run == U) sym = ".";
        else if (run == 3 * U) sym = "-";
        else begin
          chk("mark_length", run, U);
          sym = "?";
        end
        chk("strobe_matches_mark", int'(mark_dash), (sym == "-") ? 1 : 0);
        cur = {cur, sym};
        space_run = 0;
      end
      if (!key_out) space_run++;

      if (err) begin
        if (q.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          f = q.pop_front();
          chk("err_kind", f.kind, K_INV);
          chk("err_cycle", cyc - f.acc, 0);
          chk("err_ready", int'(bus.char_ready), 1);
        end
      end

      if (char_done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          f = q.pop_front();
          chk("done_kind_valid", int'(f.kind != K_INV), 1);
          chk_s("decoded_pattern", cur, exp_str(f));
          chk("occupancy_cycles", cyc - f.acc, exp_units(f) * U);
          chk("done_ready", int'(bus.char_ready), 1);
        end
        cur = "";
      end else if (q.size() > 0 && q[0].kind != K_INV && cyc >= q[0].acc) begin
        chk("busy_ready_low", int'(bus.char_ready), 0);
      end
      prev_key = key_out;
    end

    if (stim_done && q.size() == 0) begin
      settle++;
      if (settle == 20) begin
        chk("driver_stall", int'(drv_fail), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end else if (cyc >= 60000) begin
      chk("watchdog_stim_done", int'(stim_done), 1);
      chk("watchdog_pending", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
endmodule
